uart_rx_8n1: RTL and testbench

UART_RX_8N1 -- requirements
Module: uart_rx_8n1

---
 rtl/uart_rx_8n1.sv | 106 ++++++++++
 tb/tb_uart_rx_8n1.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: oversampling UART receiver, 8N1 by default, even parity when UART_RX_PARITY_EN is defined
// Ports: hw_clk system clock (rising edge), rst_n async active-low reset, uartrx serial line (idle high),
//        rx_ack consumer acknowledge, rx_data/rx_valid last good byte and its unconsumed flag,
//        frame_err/overrun/parity_err one-cycle error pulses (parity_err tied 0 without the macro).
module uart_rx_8n1 #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD = 9600,
  parameter int OVS = 16
) (
  input  logic       hw_clk,
  input  logic       rst_n,
  input  logic       uartrx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVS);
  localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, nxt;
  logic sync1, line, line_q;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tc;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic tick, half_smp, bit_smp, stop_smp, perr, good;
  assign tick = (state != IDLE) && (div_cnt == D_LAST);
  assign half_smp = tick && (tc == T_HALF);
  assign bit_smp = tick && (tc == T_LAST);
  assign stop_smp = (state == STOP) && bit_smp;
  assign good = stop_smp & line & ~perr;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign perr = par_bit != ^shift;
  always_ff @(posedge hw_clk or negedge rst_n)
    if (!rst_n) begin
      par_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit <= (state == PARITY && bit_smp) ? line : par_bit;
      parity_err <= stop_smp & perr;
    end
`else
  assign perr = 1'b0;
  assign parity_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = (line_q & ~line) ? START : IDLE;
      START:  nxt = half_smp ? (line ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   nxt = (bit_smp && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY: nxt = bit_smp ? STOP : PARITY;
`else
      DATA:   nxt = (bit_smp && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP:   nxt = bit_smp ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // line_q trails the synchronized line so only a genuine high-to-low edge starts a frame
  always_ff @(posedge hw_clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b1;
      line <= 1'b1;
      line_q <= 1'b1;
      state <= IDLE;
      div_cnt <= '0;
      tc <= '0;
      bit_cnt <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync1 <= uartrx;
      line <= sync1;
      line_q <= line;
      state <= nxt;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      tc <= (state == IDLE) ? '0 : !tick ? tc : ((state == START && half_smp) || tc == T_LAST) ? '0 : tc + 1'b1;
      bit_cnt <= (state == IDLE) ? '0 : (state == DATA && bit_smp) ? bit_cnt + 3'd1 : bit_cnt;
      shift <= (state == DATA && bit_smp) ? {line, shift[7:1]} : shift;
      rx_data <= good ? shift : rx_data;
      rx_valid <= good | (rx_valid & ~rx_ack);
      frame_err <= stop_smp & ~line;
      overrun <= good & rx_valid & ~rx_ack;
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed self-checking bench for uart_rx_8n1 (bit time scaled to 128 cycles, DIV = 8)
module tb_uart_rx_8n1;
  localparam int BIT = 128;
`ifdef UART_RX_PARITY_EN
  localparam int DLY = 1346;
`else
  localparam int DLY = 1218;
`endif
  logic hw_clk = 1'b0;
  logic rst_n = 1'b0;
  logic uartrx = 1'b1;
  logic rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, parity_err;
  int checks = 0;
  int errors = 0;
  int fe_n = 0;
  int ov_n = 0;
  int pe_n = 0;
  int base;
  uart_rx_8n1 #(.CLK_HZ(1228800), .BAUD(9600), .OVS(16)) dut (
    .hw_clk(hw_clk),
    .rst_n(rst_n),
    .uartrx(uartrx),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );
  always #5 hw_clk = ~hw_clk;
  always @(negedge hw_clk) begin
    if (frame_err) fe_n <= fe_n + 1;
    if (overrun) ov_n <= ov_n + 1;
    if (parity_err) pe_n <= pe_n + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bit_out(input logic v);
    uartrx = v;
    repeat (BIT) @(negedge hw_clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stp);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^b);
`endif
    bit_out(stp);
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(par);
    bit_out(1'b1);
  endtask
`endif
  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge hw_clk);
    #1 rx_ack = 1'b0;
    @(negedge hw_clk);
  endtask
  initial begin
    repeat (3) @(negedge hw_clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_ov", overrun, 1'b0);
    chk("rst_pe", parity_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge hw_clk);
    fork
      send(8'h44, 1'b1);
      begin
        repeat (DLY) @(posedge hw_clk);
        #1 chk("valid_before_44", rx_valid, 1'b0);
        @(posedge hw_clk);
        #1 chk("valid_44", rx_valid, 1'b1);
        chk("data_44", rx_data, 8'h44);
      end
    join
    chk("fe_44", fe_n, 0);
    rx_ack = 1'b1;
    @(posedge hw_clk);
    #1 chk("ack_clears", rx_valid, 1'b0);
    rx_ack = 1'b0;
    @(negedge hw_clk);
    uartrx = 1'b0;
    repeat (30) @(negedge hw_clk);
    uartrx = 1'b1;
    repeat (2 * BIT) @(negedge hw_clk);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_fe", fe_n, 0);
    send(8'h5A, 1'b1);
    repeat (10) @(negedge hw_clk);
    chk("data_5a", rx_data, 8'h5A);
    chk("valid_5a", rx_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge hw_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge hw_clk);
    base = fe_n;
    send(8'hA5, 1'b0);
    repeat (3 * BIT) @(negedge hw_clk);
    chk("fe_pulse_a5", fe_n - base, 1);
    chk("valid_a5", rx_valid, 1'b0);
    chk("data_a5", rx_data, 8'h00);
    uartrx = 1'b1;
    repeat (2 * BIT) @(negedge hw_clk);
    send(8'h3C, 1'b1);
    repeat (10) @(negedge hw_clk);
    chk("data_3c", rx_data, 8'h3C);
    chk("valid_3c", rx_valid, 1'b1);
    chk("fe_after_3c", fe_n - base, 1);
    ack_pulse();
    base = ov_n;
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    repeat (10) @(negedge hw_clk);
    chk("ov_pulse", ov_n - base, 1);
    chk("data_34", rx_data, 8'h34);
    chk("valid_34", rx_valid, 1'b1);
    fork
      send(8'h56, 1'b1);
      begin
        repeat (DLY) @(posedge hw_clk);
        #1 rx_ack = 1'b1;
        @(posedge hw_clk);
        #1 rx_ack = 1'b0;
      end
    join
    repeat (10) @(negedge hw_clk);
    chk("ov_ack_same", ov_n - base, 1);
    chk("data_56", rx_data, 8'h56);
    chk("valid_56", rx_valid, 1'b1);
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (4 * BIT + BIT / 2) @(negedge hw_clk);
        rst_n = 1'b0;
        #1 chk("midrst_data", rx_data, 8'h00);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_fe", frame_err, 1'b0);
        chk("midrst_ov", overrun, 1'b0);
        repeat (20) @(negedge hw_clk);
        rst_n = 1'b1;
      end
    join
    repeat (BIT) @(negedge hw_clk);
    chk("abandoned_valid", rx_valid, 1'b0);
    send(8'h81, 1'b1);
    repeat (10) @(negedge hw_clk);
    chk("data_81", rx_data, 8'h81);
    chk("valid_81", rx_valid, 1'b1);
`ifdef UART_RX_PARITY_EN
    ack_pulse();
    base = pe_n;
    send_par(8'h07, 1'b0);
    repeat (10) @(negedge hw_clk);
    chk("pe_pulse", pe_n - base, 1);
    chk("pe_valid", rx_valid, 1'b0);
    chk("pe_data", rx_data, 8'h81);
    send_par(8'h07, 1'b1);
    repeat (10) @(negedge hw_clk);
    chk("data_07", rx_data, 8'h07);
    chk("valid_07", rx_valid, 1'b1);
    chk("pe_after_07", pe_n - base, 1);
`else
    chk("pe_never", pe_n, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
